// File: rtl/vram_pkg.sv
// Shared constants and types for the 160x100 RGB332 framebuffer arbiter.
// Pixel (x, y) lives at address y*FB_W + x, one byte per pixel.
package vram_pkg;
  localparam int FB_W     = 160;
  localparam int FB_H     = 100;
  localparam int FB_DEPTH = FB_W * FB_H;
  localparam int ADDR_W   = 14;
  localparam int DATA_W   = 8;

  typedef enum logic [1:0] {IDLE, FILL, DONE} fill_state_t;
endpackage

// File: rtl/vram_wr_fifo.sv
// Small synchronous FIFO buffering CPU framebuffer writes.
// Registered occupancy count; full/empty are decoded from it.
module vram_wr_fifo
  import vram_pkg::*;
#(
  parameter int WIDTH = ADDR_W + DATA_W,
  parameter int DEPTH = 4
) (
  input  logic             pclk,
  input  logic             reset,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_data,
  output logic             o_full,
  output logic             o_empty
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W:0]   r_count;
  logic             w_push;
  logic             w_pop;

  assign o_full  = (r_count == FULL_CNT);
  assign o_empty = (r_count == '0);
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;
  assign o_data  = r_mem[r_rd_ptr];

  // NOTE: the storage array carries no reset; emptiness is defined by the count alone.
  always_ff @(posedge pclk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_data;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge pclk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end
endmodule

// File: rtl/vram_arbiter.sv
// Single-port framebuffer RAM arbiter: display reads > CPU write FIFO > clear/fill engine.
// RAM controls are combinational from the grant; display reads return with fixed latency 2.
module vram_arbiter #(
  parameter int ADDR_W     = vram_pkg::ADDR_W,
  parameter int DATA_W     = vram_pkg::DATA_W,
  parameter int DEPTH      = vram_pkg::FB_DEPTH,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              pclk,
  input  logic              reset,
  input  logic              vid_req,
  input  logic [ADDR_W-1:0] vid_addr,
  output logic [DATA_W-1:0] vid_data,
  output logic              vid_valid,
  input  logic              cpu_wr_valid,
  output logic              cpu_wr_ready,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_data,
  input  logic              fill_start,
  input  logic [DATA_W-1:0] fill_value,
  output logic              fill_busy,
  output logic              fill_done,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
);
  import vram_pkg::*;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wr_req_t;

  localparam logic [ADDR_W:0]   DEPTH_X   = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  wr_req_t           w_cpu_req;
  wr_req_t           w_head;
  logic              w_fifo_full;
  logic              w_fifo_empty;
  logic              w_grant_vid;
  logic              w_grant_cpu;
  logic              w_grant_fill;
  logic              w_vid_in_range;
  logic              w_head_in_range;
  fill_state_t       r_state;
  fill_state_t       w_state_nxt;
  logic [ADDR_W-1:0] r_fill_cnt;
  logic [DATA_W-1:0] r_fill_val;
  logic              r_vid_p1;
  logic              r_vid_oor_p1;
  logic              r_vid_valid;
  logic [DATA_W-1:0] r_vid_data;

  assign w_cpu_req       = '{addr: cpu_addr, data: cpu_data};
  assign cpu_wr_ready    = !reset && !w_fifo_full;
  assign w_vid_in_range  = ({1'b0, vid_addr} < DEPTH_X);
  assign w_head_in_range = ({1'b0, w_head.addr} < DEPTH_X);

  vram_wr_fifo #(
    .WIDTH (ADDR_W + DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_wr_fifo (
    .pclk    (pclk),
    .reset   (reset),
    .i_push  (cpu_wr_valid && cpu_wr_ready),
    .i_data  (w_cpu_req),
    .i_pop   (w_grant_cpu),
    .o_data  (w_head),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty)
  );

  // Fixed priority, one access per cycle; nothing is granted while reset is held.
  assign w_grant_vid  = !reset && vid_req;
  assign w_grant_cpu  = !reset && !vid_req && !w_fifo_empty;
  assign w_grant_fill = !reset && !vid_req && w_fifo_empty && (r_state == FILL);

  // NOTE: every combinational output gets a default first, so no path can infer a latch.
  always_comb begin
    ram_addr  = '0;
    ram_we    = 1'b0;
    ram_wdata = '0;
    if (w_grant_vid) begin
      ram_addr = vid_addr;
    end else if (w_grant_cpu) begin
      ram_addr  = w_head.addr;
      ram_we    = w_head_in_range;
      ram_wdata = w_head.data;
    end else if (w_grant_fill) begin
      ram_addr  = r_fill_cnt;
      ram_we    = 1'b1;
      ram_wdata = r_fill_val;
    end
  end

  always_ff @(posedge pclk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (fill_start) w_state_nxt = FILL;
      FILL:    if (w_grant_fill && (r_fill_cnt == LAST_ADDR)) w_state_nxt = DONE;
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  assign fill_busy = (r_state == FILL);
  assign fill_done = (r_state == DONE);

  // The counter parks on the last address instead of stepping past the framebuffer.
  always_ff @(posedge pclk) begin
    if (reset) begin
      r_fill_cnt <= '0;
      r_fill_val <= '0;
    end else if ((r_state == IDLE) && fill_start) begin
      r_fill_cnt <= '0;
      r_fill_val <= fill_value;
    end else if (w_grant_fill && (r_fill_cnt != LAST_ADDR)) begin
      r_fill_cnt <= r_fill_cnt + 1'b1;
    end
  end

  // Stage 1 waits for the RAM's one-cycle read; stage 2 registers the returned byte.
  always_ff @(posedge pclk) begin
    if (reset) begin
      r_vid_p1     <= 1'b0;
      r_vid_oor_p1 <= 1'b0;
      r_vid_valid  <= 1'b0;
      r_vid_data   <= '0;
    end else begin
      r_vid_p1     <= w_grant_vid;
      r_vid_oor_p1 <= !w_vid_in_range;
      r_vid_valid  <= r_vid_p1;
      if (r_vid_p1) r_vid_data <= r_vid_oor_p1 ? '0 : ram_rdata;
    end
  end

  assign vid_valid = r_vid_valid;
  assign vid_data  = r_vid_data;
endmodule

// File: tb/tb_vram_arbiter.sv
// Self-checking bench for vram_arbiter: behavioural RAM, queue-based reference model,
// randomized traffic plus directed reset, latency, FIFO back-pressure and fill scenarios.
module tb_vram_arbiter;
  import vram_pkg::*;

  logic              pclk = 1'b0;
  logic              reset;
  logic              vid_req;
  logic [ADDR_W-1:0] vid_addr;
  logic [DATA_W-1:0] vid_data;
  logic              vid_valid;
  logic              cpu_wr_valid;
  logic              cpu_wr_ready;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_data;
  logic              fill_start;
  logic [DATA_W-1:0] fill_value;
  logic              fill_busy;
  logic              fill_done;
  logic [ADDR_W-1:0] ram_addr;
  logic              ram_we;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;

  always #5 pclk = ~pclk;

  vram_arbiter #(
    .ADDR_W     (ADDR_W),
    .DATA_W     (DATA_W),
    .DEPTH      (FB_DEPTH),
    .FIFO_DEPTH (4)
  ) dut (
    .pclk         (pclk),
    .reset        (reset),
    .vid_req      (vid_req),
    .vid_addr     (vid_addr),
    .vid_data     (vid_data),
    .vid_valid    (vid_valid),
    .cpu_wr_valid (cpu_wr_valid),
    .cpu_wr_ready (cpu_wr_ready),
    .cpu_addr     (cpu_addr),
    .cpu_data     (cpu_data),
    .fill_start   (fill_start),
    .fill_value   (fill_value),
    .fill_busy    (fill_busy),
    .fill_done    (fill_done),
    .ram_addr     (ram_addr),
    .ram_we       (ram_we),
    .ram_wdata    (ram_wdata),
    .ram_rdata    (ram_rdata)
  );

  // External single-port RAM: read data appears one cycle after the address.
  logic [7:0] ram_mem [16384];
  always @(posedge pclk) begin
    if (ram_we) ram_mem[ram_addr] <= ram_wdata;
    ram_rdata <= ram_mem[ram_addr];
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: expected framebuffer, queue of accepted CPU writes, fill progress.
  typedef struct {
    int         addr;
    logic [7:0] data;
  } wr_t;

  logic [7:0] exp_mem [16384];
  wr_t        m_q[$];
  bit         m_filling;
  bit         m_done;
  int         m_fill_next;
  logic [7:0] m_fill_val;
  bit         m_rd_v [2];
  logic [7:0] m_rd_d [2];

  logic       s_ram_we, s_ready, s_busy, s_done, s_vid_valid;
  logic [13:0] s_ram_addr;
  logic [7:0] s_ram_wdata, s_vid_data;

  // One clock cycle: settle, compare against model, advance model, move to next negedge.
  task automatic step();
    bit         exp_ready;
    bit         fill_last;
    logic [7:0] rd;
    wr_t        w;
    #1;
    s_ram_we    = ram_we;
    s_ram_addr  = ram_addr;
    s_ram_wdata = ram_wdata;
    s_ready     = cpu_wr_ready;
    s_busy      = fill_busy;
    s_done      = fill_done;
    s_vid_valid = vid_valid;
    s_vid_data  = vid_data;
    exp_ready   = !reset && (m_q.size() < 4);
    fill_last   = 1'b0;
    rd          = 8'h00;
    check("cpu_wr_ready", cpu_wr_ready, exp_ready);
    check("fill_busy", fill_busy, m_filling);
    check("fill_done", fill_done, m_done);
    check("vid_valid", vid_valid, m_rd_v[1]);
    if (m_rd_v[1]) check("vid_data", vid_data, m_rd_d[1]);
    if (reset) begin
      check("ram_we_rst", ram_we, 0);
      check("ram_addr_rst", ram_addr, 0);
    end else if (vid_req) begin
      check("ram_we_vid", ram_we, 0);
      check("ram_addr_vid", ram_addr, vid_addr);
      rd = (int'(vid_addr) < FB_DEPTH) ? exp_mem[vid_addr] : 8'h00;
    end else if (m_q.size() > 0) begin
      w = m_q.pop_front();
      if (w.addr < FB_DEPTH) begin
        check("ram_we_cpu", ram_we, 1);
        check("ram_addr_cpu", ram_addr, w.addr);
        check("ram_wdata_cpu", ram_wdata, w.data);
        exp_mem[w.addr] = w.data;
      end else begin
        check("ram_we_cpu_oor", ram_we, 0);
      end
    end else if (m_filling) begin
      check("ram_we_fill", ram_we, 1);
      check("ram_addr_fill", ram_addr, m_fill_next);
      check("ram_wdata_fill", ram_wdata, m_fill_val);
      exp_mem[m_fill_next] = m_fill_val;
      fill_last = (m_fill_next == FB_DEPTH - 1);
      m_fill_next++;
    end else begin
      check("ram_we_idle", ram_we, 0);
    end

    if (reset) begin
      m_q.delete();
      m_filling = 0;
      m_done    = 0;
      m_rd_v    = '{0, 0};
    end else begin
      m_rd_v[1] = m_rd_v[0];
      m_rd_d[1] = m_rd_d[0];
      m_rd_v[0] = vid_req;
      m_rd_d[0] = rd;
      if (cpu_wr_valid && exp_ready) m_q.push_back('{int'(cpu_addr), cpu_data});
      if (m_done) begin
        m_done = 0;
      end else if (m_filling) begin
        if (fill_last) begin
          m_filling = 0;
          m_done    = 1;
        end
      end else if (fill_start) begin
        m_filling   = 1;
        m_fill_next = 0;
        m_fill_val  = fill_value;
      end
    end
    @(posedge pclk);
    @(negedge pclk);
  endtask

  task automatic idle_inputs();
    vid_req      = 0;
    cpu_wr_valid = 0;
    fill_start   = 0;
  endtask

  function automatic logic [13:0] rand_addr();
    if ($urandom_range(0, 15) == 0) return 14'($urandom_range(16000, 16383));
    return 14'($urandom_range(0, 15999));
  endfunction

  task automatic vid_read(input int addr, input logic [7:0] exp);
    idle_inputs();
    step();
    vid_req  = 1;
    vid_addr = 14'(addr);
    step();
    vid_req = 0;
    step();
    check("vid_not_early", s_vid_valid, 0);
    step();
    check($sformatf("vid_valid_n2[%0d]", addr), s_vid_valid, 1);
    check($sformatf("vid_data_n2[%0d]", addr), s_vid_data, exp);
  endtask

  task automatic rand_traffic(input int n);
    for (int i = 0; i < n; i++) begin
      vid_req      = ($urandom_range(0, 3) == 0);
      vid_addr     = rand_addr();
      cpu_wr_valid = $urandom_range(0, 1);
      cpu_addr     = rand_addr();
      cpu_data     = 8'($urandom);
      step();
    end
    idle_inputs();
  endtask

  initial begin
    logic [13:0] qa [5];
    logic [7:0]  qd [5];
    int accepted, nw, done_k, n_rd, n_val, n_fw, n_done, mism;

    for (int i = 0; i < 16384; i++) ram_mem[i] = 8'($urandom);
    ram_mem[5]     = 8'hE3;
    ram_mem[16000] = 8'hA5;
    for (int i = 0; i < 16384; i++) exp_mem[i] = ram_mem[i];

    reset = 1;
    idle_inputs();
    vid_addr = '0; cpu_addr = '0; cpu_data = '0; fill_value = '0;
    repeat (3) @(posedge pclk);
    @(negedge pclk);
    reset = 0;
    m_filling = 0; m_done = 0; m_rd_v = '{0, 0}; m_rd_d = '{8'h00, 8'h00};

    // Reset state
    step();
    check("rst_vid_valid", s_vid_valid, 0);
    check("rst_vid_data", s_vid_data, 8'h00);
    check("rst_ram_we", s_ram_we, 0);
    check("rst_ram_addr", s_ram_addr, 0);
    check("rst_ram_wdata", s_ram_wdata, 0);
    check("rst_ready", s_ready, 1);
    check("rst_busy", s_busy, 0);
    check("rst_done", s_done, 0);

    // Read latency, in-range and out-of-range
    vid_read(5, 8'hE3);
    vid_read(16000, 8'h00);

    // FIFO back-pressure with the display hogging every slot
    for (int i = 0; i < 5; i++) begin
      qa[i] = 14'(200 + 7 * i);
      qd[i] = 8'(8'h10 + i);
    end
    accepted = 0;
    vid_req = 1; cpu_wr_valid = 1;
    for (int c = 0; c < 12 && accepted < 4; c++) begin
      vid_addr = 14'($urandom_range(0, 15999));
      cpu_addr = qa[accepted];
      cpu_data = qd[accepted];
      step();
      check("q_no_write_while_vid", s_ram_we, 0);
      if (s_ready) accepted++;
    end
    check("q_accepts_before_full", accepted, 4);
    cpu_addr = qa[4]; cpu_data = qd[4];
    step();
    check("q_full_ready", s_ready, 0);
    check("q_full_no_write", s_ram_we, 0);
    vid_req = 0;
    nw = 0;
    for (int c = 0; c < 12 && nw < 5; c++) begin
      step();
      if (c == 0) check("q_no_bypass", s_ready, 0);
      if (cpu_wr_valid && s_ready) begin
        accepted++;
        cpu_wr_valid = 0;
      end
      if (s_ram_we) begin
        check($sformatf("q_order_addr%0d", nw), s_ram_addr, qa[nw]);
        check($sformatf("q_order_data%0d", nw), s_ram_wdata, qd[nw]);
        nw++;
      end
    end
    check("q_fifth_accepted", accepted, 5);
    check("q_drained", nw, 5);
    idle_inputs();

    rand_traffic(1500);

    // Fill aborted by reset
    fill_start = 1; fill_value = 8'h33;
    step();
    fill_start = 0;
    rand_traffic(2000);
    step();
    check("abort_busy_before", s_busy, 1);
    reset = 1;
    step();
    step();
    reset = 0;
    step();
    check("abort_busy_after", s_busy, 0);
    check("abort_ready_after", s_ready, 1);
    n_done = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (s_done) n_done++;
    end
    check("abort_no_done", n_done, 0);

    // Full fill with no other traffic; a second start mid-fill is ignored
    fill_start = 1; fill_value = 8'h1C;
    step();
    done_k = 0;
    for (int k = 1; k <= 20000; k++) begin
      fill_start = (k == 100);
      fill_value = (k == 100) ? 8'h77 : 8'h1C;
      step();
      if (s_done) begin
        done_k = k;
        break;
      end
    end
    fill_start = 0;
    check("fill_done_latency", done_k, 16001);
    vid_read(0, 8'h1C);
    vid_read(7999, 8'h1C);
    vid_read(15999, 8'h1C);

    // Fill interleaved with display reads every 4th cycle and two CPU writes
    fill_start = 1; fill_value = 8'h5A;
    step();
    fill_start = 0;
    done_k = 0; n_rd = 0; n_val = 0; n_fw = 0;
    for (int k = 1; k <= 30000; k++) begin
      vid_req      = (k % 4 == 0);
      vid_addr     = 14'($urandom_range(0, 15999));
      cpu_wr_valid = (k == 10) || (k == 15000);
      cpu_addr     = (k == 10) ? 14'd15990 : 14'd3;
      cpu_data     = 8'hFF;
      step();
      if (vid_req) n_rd++;
      if (s_vid_valid) n_val++;
      if (s_ram_we && s_ram_wdata == 8'h5A) n_fw++;
      if (s_done) begin
        done_k = k;
        break;
      end
    end
    idle_inputs();
    step();
    if (s_vid_valid) n_val++;
    step();
    if (s_vid_valid) n_val++;
    check("mix_fill_completed", done_k != 0, 1);
    check("mix_fill_writes", n_fw, 16000);
    check("mix_reads_returned", n_val, n_rd);
    vid_read(15990, 8'h5A);
    vid_read(3, 8'hFF);
    check("mix_ram_15990", ram_mem[15990], 8'h5A);
    check("mix_ram_3", ram_mem[3], 8'hFF);

    rand_traffic(300);
    step();
    step();

    mism = 0;
    for (int i = 0; i < 16384; i++) if (ram_mem[i] !== exp_mem[i]) mism++;
    check("final_ram_contents", mism, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
